// File: rtl/cvxif_copro_responder.sv
// CV-X-IF coprocessor responder: decodes custom-3 ADD/SUB/NOP/MUL, buffers accepted
// instructions until commit/kill, executes them in issue order and returns results.
module cvxif_copro_responder #(
   parameter int unsigned Xlen       = 32,
   parameter int unsigned IdWidth    = 3,
   parameter int unsigned FifoDepth  = 4,
   parameter int unsigned MulLatency = 3
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               x_issue_valid_i,
   output logic               x_issue_ready_o,
   input  logic [31:0]        x_issue_instr_i,
   input  logic [Xlen-1:0]    x_issue_rs1_i,
   input  logic [Xlen-1:0]    x_issue_rs2_i,
   input  logic [IdWidth-1:0] x_issue_id_i,
   output logic               x_issue_accept_o,
   output logic               x_issue_writeback_o,
   input  logic               x_commit_valid_i,
   input  logic [IdWidth-1:0] x_commit_id_i,
   input  logic               x_commit_kill_i,
   output logic               x_result_valid_o,
   input  logic               x_result_ready_i,
   output logic [IdWidth-1:0] x_result_id_o,
   output logic [Xlen-1:0]    x_result_data_o,
   output logic [4:0]         x_result_rd_o,
   output logic               x_result_we_o
);

   localparam int unsigned PtrW = $clog2(FifoDepth);
   localparam int unsigned CntW = PtrW + 1;
   localparam int unsigned LatW = (MulLatency > 1) ? $clog2(MulLatency) : 1;

   typedef enum logic [1:0] {OP_ADD = 2'd0, OP_SUB = 2'd1, OP_NOP = 2'd2, OP_MUL = 2'd3} op_e;
   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;

   typedef struct packed {
      logic [IdWidth-1:0] id;
      op_e                op;
      logic [Xlen-1:0]    rs1;
      logic [Xlen-1:0]    rs2;
      logic [4:0]         rd;
      logic               committed;
      logic               killed;
   } entry_t;

   entry_t             mem_q [FifoDepth];
   entry_t             mem_d [FifoDepth];
   logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]    count_q, count_d;
   state_e             state_q, state_d;
   logic [LatW-1:0]    cnt_q, cnt_d;
   logic [Xlen-1:0]    mul_a_q, mul_a_d, mul_b_q, mul_b_d;
   logic               res_valid_q, res_valid_d;
   logic [IdWidth-1:0] res_id_q, res_id_d;
   logic [Xlen-1:0]    res_data_q, res_data_d;
   logic [4:0]         res_rd_q, res_rd_d;
   logic               res_we_q, res_we_d;

   logic               dec_match_c, push_c, pop_c, new_hit_c;
   logic               head_hit_c, head_commit_c, head_kill_c;
   logic [FifoDepth-1:0] live_c;
   entry_t             head_c;
   logic               unused_c;

   // Decode: custom-3 opcode, funct7 zero, funct3 in 0..3
   assign dec_match_c = (x_issue_instr_i[6:0] == 7'h7B) && (x_issue_instr_i[31:25] == 7'h00)
                        && !x_issue_instr_i[14];
   assign x_issue_accept_o    = dec_match_c;
   assign x_issue_writeback_o = dec_match_c && (x_issue_instr_i[13:12] != 2'd2);
   assign x_issue_ready_o     = (count_q != CntW'(FifoDepth));
   assign push_c    = x_issue_valid_i && x_issue_ready_o && dec_match_c;
   assign new_hit_c = x_commit_valid_i && (x_commit_id_i == x_issue_id_i);
   assign unused_c  = ^x_issue_instr_i[24:15];

   // A commit in the same cycle as the head decision takes effect immediately
   assign head_c        = mem_q[rd_ptr_q];
   assign head_hit_c    = x_commit_valid_i && (x_commit_id_i == head_c.id);
   assign head_commit_c = head_c.committed || (head_hit_c && !x_commit_kill_i);
   assign head_kill_c   = head_c.killed || (head_hit_c && x_commit_kill_i);

   always_comb begin
      live_c = '0;
      for (int i = 0; i < FifoDepth; i++) begin
         live_c[i] = CntW'(PtrW'(PtrW'(i) - rd_ptr_q)) < count_q;
      end
   end

   always_comb begin
      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      state_d     = state_q;
      cnt_d       = cnt_q;
      mul_a_d     = mul_a_q;
      mul_b_d     = mul_b_q;
      res_valid_d = res_valid_q;
      res_id_d    = res_id_q;
      res_data_d  = res_data_q;
      res_rd_d    = res_rd_q;
      res_we_d    = res_we_q;
      pop_c       = 1'b0;

      for (int i = 0; i < FifoDepth; i++) begin
         if (live_c[i] && x_commit_valid_i && (mem_q[i].id == x_commit_id_i)) begin
            if (x_commit_kill_i) mem_d[i].killed = 1'b1;
            else                 mem_d[i].committed = 1'b1;
         end
      end

      if (push_c) begin
         mem_d[wr_ptr_q] = '{id: x_issue_id_i, op: op_e'(x_issue_instr_i[13:12]),
                             rs1: x_issue_rs1_i, rs2: x_issue_rs2_i, rd: x_issue_instr_i[11:7],
                             committed: new_hit_c && !x_commit_kill_i,
                             killed: new_hit_c && x_commit_kill_i};
         wr_ptr_d = wr_ptr_q + PtrW'(1);
      end

      unique case (state_q)
         S_IDLE: begin
            if (count_q != '0 && (head_kill_c || head_commit_c)) begin
               pop_c    = 1'b1;
               rd_ptr_d = rd_ptr_q + PtrW'(1);
               if (!head_kill_c && head_c.op != OP_NOP) begin
                  res_id_d = head_c.id;
                  res_rd_d = head_c.rd;
                  res_we_d = 1'b1;
                  if (head_c.op == OP_MUL && MulLatency > 1) begin
                     mul_a_d = head_c.rs1;
                     mul_b_d = head_c.rs2;
                     cnt_d   = LatW'(MulLatency - 1);
                     state_d = S_EXEC;
                  end else begin
                     unique case (head_c.op)
                        OP_ADD:  res_data_d = head_c.rs1 + head_c.rs2;
                        OP_SUB:  res_data_d = head_c.rs1 - head_c.rs2;
                        default: res_data_d = head_c.rs1 * head_c.rs2;
                     endcase
                     res_valid_d = 1'b1;
                     state_d     = S_RESP;
                  end
               end
            end
         end
         S_EXEC: begin
            if (cnt_q <= LatW'(1)) begin
               res_data_d  = mul_a_q * mul_b_q;
               res_valid_d = 1'b1;
               cnt_d       = '0;
               state_d     = S_RESP;
            end else begin
               cnt_d = cnt_q - LatW'(1);
            end
         end
         S_RESP: begin
            if (x_result_ready_i) begin
               res_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      count_d = count_q + CntW'(push_c) - CntW'(pop_c);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         res_valid_q <= 1'b0;
         res_id_q    <= '0;
         res_data_q  <= '0;
         res_rd_q    <= '0;
         res_we_q    <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mul_a_q     <= mul_a_d;
         mul_b_q     <= mul_b_d;
         res_valid_q <= res_valid_d;
         res_id_q    <= res_id_d;
         res_data_q  <= res_data_d;
         res_rd_q    <= res_rd_d;
         res_we_q    <= res_we_d;
      end
   end

   // Payload storage needs no reset: liveness comes from the pointers and count
   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

   assign x_result_valid_o = res_valid_q;
   assign x_result_id_o    = res_id_q;
   assign x_result_data_o  = res_data_q;
   assign x_result_rd_o    = res_rd_q;
   assign x_result_we_o    = res_we_q;

endmodule

// File: tb/tb_cvxif_copro_responder.sv
// Directed bench for cvxif_copro_responder with an in-order result scoreboard.
module tb_cvxif_copro_responder;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        x_issue_valid_i, x_issue_ready_o;
   logic [31:0] x_issue_instr_i, x_issue_rs1_i, x_issue_rs2_i;
   logic [2:0]  x_issue_id_i;
   logic        x_issue_accept_o, x_issue_writeback_o;
   logic        x_commit_valid_i, x_commit_kill_i;
   logic [2:0]  x_commit_id_i;
   logic        x_result_valid_o, x_result_ready_i;
   logic [2:0]  x_result_id_o;
   logic [31:0] x_result_data_o;
   logic [4:0]  x_result_rd_o;
   logic        x_result_we_o;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [2:0]  id;
      logic [31:0] data;
      logic [4:0]  rd;
   } exp_t;
   exp_t sb[$];

   logic [31:0] m_a [8];
   logic [31:0] m_b [8];
   logic [2:0]  m_f3 [8];
   logic [4:0]  m_rd [8];

   cvxif_copro_responder dut (
      .clk_i(clk), .rst_i(rst_i),
      .x_issue_valid_i(x_issue_valid_i), .x_issue_ready_o(x_issue_ready_o),
      .x_issue_instr_i(x_issue_instr_i), .x_issue_rs1_i(x_issue_rs1_i),
      .x_issue_rs2_i(x_issue_rs2_i), .x_issue_id_i(x_issue_id_i),
      .x_issue_accept_o(x_issue_accept_o), .x_issue_writeback_o(x_issue_writeback_o),
      .x_commit_valid_i(x_commit_valid_i), .x_commit_id_i(x_commit_id_i),
      .x_commit_kill_i(x_commit_kill_i),
      .x_result_valid_o(x_result_valid_o), .x_result_ready_i(x_result_ready_i),
      .x_result_id_o(x_result_id_o), .x_result_data_o(x_result_data_o),
      .x_result_rd_o(x_result_rd_o), .x_result_we_o(x_result_we_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd);
      return {7'h00, 5'd2, 5'd1, f3, rd, opc};
   endfunction

   function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      case (f3)
         3'd0:    return a + b;
         3'd1:    return a - b;
         default: return a * b;
      endcase
   endfunction

   task automatic issue(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] id, input logic exp_acc, input logic exp_wb);
      x_issue_valid_i = 1'b1;
      x_issue_instr_i = instr;
      x_issue_rs1_i   = a;
      x_issue_rs2_i   = b;
      x_issue_id_i    = id;
      m_a[id] = a; m_b[id] = b; m_f3[id] = instr[14:12]; m_rd[id] = instr[11:7];
      #1;
      check("issue_ready", 32'(x_issue_ready_o), 32'd1);
      check("issue_accept", 32'(x_issue_accept_o), 32'(exp_acc));
      check("issue_writeback", 32'(x_issue_writeback_o), 32'(exp_wb));
      tick();
      x_issue_valid_i = 1'b0;
   endtask

   task automatic commit(input logic [2:0] id, input logic kill, input bit exp_res);
      exp_t e;
      if (exp_res) begin
         e.id = id; e.rd = m_rd[id]; e.data = model(m_f3[id], m_a[id], m_b[id]);
         sb.push_back(e);
      end
      x_commit_valid_i = 1'b1;
      x_commit_id_i    = id;
      x_commit_kill_i  = kill;
      tick();
      x_commit_valid_i = 1'b0;
      x_commit_kill_i  = 1'b0;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 60 && sb.size() != 0; i++) tick();
      check(tag, 32'(sb.size()), 32'd0);
      tick();
      check({tag, "_idle"}, 32'(x_result_valid_o), 32'd0);
   endtask

   // Scoreboard: every accepted result must match the oldest expected entry
   always @(negedge clk) begin
      if (!rst_i && x_result_valid_o && x_result_ready_i) begin
         exp_t e;
         checks++;
         assert (sb.size() != 0) else begin
            failures++;
            $error("FAIL res_unexpected: observed id=%0d data=%0h expected no result", x_result_id_o, x_result_data_o);
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("res_id", 32'(x_result_id_o), 32'(e.id));
            check("res_data", x_result_data_o, e.data);
            check("res_rd", 32'(x_result_rd_o), 32'(e.rd));
            check("res_we", 32'(x_result_we_o), 32'd1);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] ins;
      rst_i = 1'b1;
      x_issue_valid_i = 1'b0; x_issue_instr_i = '0; x_issue_rs1_i = '0; x_issue_rs2_i = '0;
      x_issue_id_i = '0; x_commit_valid_i = 1'b0; x_commit_id_i = '0; x_commit_kill_i = 1'b0;
      x_result_ready_i = 1'b1;
      tick(); tick();
      rst_i = 1'b0;
      tick();
      check("rst_ready", 32'(x_issue_ready_o), 32'd1);
      check("rst_valid", 32'(x_result_valid_o), 32'd0);
      check("rst_id", 32'(x_result_id_o), 32'd0);
      check("rst_data", x_result_data_o, 32'd0);
      check("rst_rd", 32'(x_result_rd_o), 32'd0);
      check("rst_we", 32'(x_result_we_o), 32'd0);

      // ADD: result one cycle after commit
      issue(mk(7'h7B, 3'd0, 5'd1), 32'h5, 32'h7, 3'd2, 1'b1, 1'b1);
      commit(3'd2, 1'b0, 1'b1);
      check("add_valid", 32'(x_result_valid_o), 32'd1);
      check("add_data", x_result_data_o, 32'hC);
      tick();
      check("add_done", 32'(x_result_valid_o), 32'd0);

      // MUL with back-pressure
      x_result_ready_i = 1'b0;
      issue(mk(7'h7B, 3'd3, 5'd5), 32'h10, 32'h3, 3'd4, 1'b1, 1'b1);
      commit(3'd4, 1'b0, 1'b1);
      check("mul_lat1", 32'(x_result_valid_o), 32'd0);
      tick();
      check("mul_lat2", 32'(x_result_valid_o), 32'd0);
      tick();
      for (int i = 0; i < 5; i++) begin
         check("mul_hold_valid", 32'(x_result_valid_o), 32'd1);
         check("mul_hold_data", x_result_data_o, 32'h30);
         check("mul_hold_id", 32'(x_result_id_o), 32'd4);
         tick();
      end
      x_result_ready_i = 1'b1;
      tick();
      check("mul_done", 32'(x_result_valid_o), 32'd0);

      // Rejected encodings and NOP produce no result
      issue(mk(7'h33, 3'd0, 5'd9), 32'h1, 32'h2, 3'd5, 1'b0, 1'b0);
      issue(mk(7'h7B, 3'd4, 5'd9), 32'h1, 32'h2, 3'd6, 1'b0, 1'b0);
      ins = mk(7'h7B, 3'd0, 5'd9) | 32'h0200_0000;
      issue(ins, 32'h1, 32'h2, 3'd3, 1'b0, 1'b0);
      issue(mk(7'h7B, 3'd2, 5'd9), 32'h1, 32'h2, 3'd7, 1'b1, 1'b0);
      commit(3'd5, 1'b0, 1'b0);
      commit(3'd7, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         check("reject_no_result", 32'(x_result_valid_o), 32'd0);
         tick();
      end

      // Four ADD/SUB, id 1 killed: results for 0, 2, 3 in order
      for (int i = 0; i < 4; i++)
         issue(mk(7'h7B, 3'(i % 2), 5'(10 + i)), 32'(100 * (i + 1)), 32'(i + 3), 3'(i), 1'b1, 1'b1);
      commit(3'd0, 1'b0, 1'b1);
      commit(3'd1, 1'b1, 1'b0);
      commit(3'd2, 1'b0, 1'b1);
      commit(3'd3, 1'b0, 1'b1);
      drain("kill_drain");

      // Fill the buffer: ready drops, reasserts after the first pop
      for (int i = 0; i < 4; i++)
         issue(mk(7'h7B, 3'd0, 5'(20 + i)), 32'(i), 32'h1000, 3'(i), 1'b1, 1'b1);
      check("full_ready", 32'(x_issue_ready_o), 32'd0);
      tick();
      check("full_ready_hold", 32'(x_issue_ready_o), 32'd0);
      sb.push_back('{id: 3'd0, data: 32'h1000, rd: 5'd20});
      x_commit_valid_i = 1'b1; x_commit_id_i = 3'd0; x_commit_kill_i = 1'b0;
      #1;
      check("full_pop_ready", 32'(x_issue_ready_o), 32'd0);
      tick();
      x_commit_valid_i = 1'b0;
      check("after_pop_ready", 32'(x_issue_ready_o), 32'd1);
      commit(3'd1, 1'b0, 1'b1);
      commit(3'd2, 1'b0, 1'b1);
      commit(3'd3, 1'b0, 1'b1);
      drain("full_drain");

      // Reset during MUL execute with two entries pending
      issue(mk(7'h7B, 3'd3, 5'd7), 32'h6, 32'h7, 3'd1, 1'b1, 1'b1);
      issue(mk(7'h7B, 3'd0, 5'd8), 32'h1, 32'h1, 3'd2, 1'b1, 1'b1);
      issue(mk(7'h7B, 3'd0, 5'd9), 32'h2, 32'h2, 3'd3, 1'b1, 1'b1);
      commit(3'd1, 1'b0, 1'b0);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      check("midrst_ready", 32'(x_issue_ready_o), 32'd1);
      check("midrst_valid", 32'(x_result_valid_o), 32'd0);
      check("midrst_data", x_result_data_o, 32'd0);
      check("midrst_we", 32'(x_result_we_o), 32'd0);
      commit(3'd2, 1'b0, 1'b0);
      commit(3'd3, 1'b0, 1'b0);
      commit(3'd1, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         check("midrst_no_result", 32'(x_result_valid_o), 32'd0);
         tick();
      end
      check("final_sb_empty", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cvxif_copro_responder.md
Name: cvxif_copro_responder

Overview:
- Coprocessor end of the CV-X-IF: responds to issue requests from the core's issue stage, holds accepted instructions until commit or kill, executes them, and returns results over the result channel.
- Implements four custom-3 (opcode 7'h7B) integer instructions.
- Used as the default coprocessor in XLEN=32 configurations with CV-X-IF enabled.

Parameters:
- Xlen, 32, operand and result width.
- IdWidth, 3, instruction id width.
- FifoDepth, 4, pending-instruction buffer entries (power of two, ≥2).
- MulLatency, 3, execute cycles for CUS_MUL (≥1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- x_issue_valid_i  in  1  issue request valid.
- x_issue_ready_o  out  1  issue request ready.
- x_issue_instr_i  in  32  instruction word.
- x_issue_rs1_i  in  Xlen  rs1 value.
- x_issue_rs2_i  in  Xlen  rs2 value.
- x_issue_id_i  in  IdWidth  instruction id.
- x_issue_accept_o  out  1  instruction recognised (valid with the issue handshake).
- x_issue_writeback_o  out  1  accepted instruction will write rd.
- x_commit_valid_i  in  1  commit message valid.
- x_commit_id_i  in  IdWidth  committed/killed id.
- x_commit_kill_i  in  1  1 = discard the instruction.
- x_result_valid_o  out  1  result valid.
- x_result_ready_i  in  1  result ready.
- x_result_id_o  out  IdWidth  result id.
- x_result_data_o  out  Xlen  result data.
- x_result_rd_o  out  5  destination register.
- x_result_we_o  out  1  write enable.

Behaviour:
- Decode (combinational on x_issue_instr_i): match requires opcode 7'h7B and funct7 = 0.
  - funct3 0 CUS_ADD: rs1+rs2.
  - funct3 1 CUS_SUB: rs1-rs2.
  - funct3 2 CUS_NOP: no writeback.
  - funct3 3 CUS_MUL: low Xlen bits of rs1*rs2.
  - Any other encoding: accept=0, writeback=0.
- x_issue_writeback_o = accept & (funct3 != 2).
- Handshake = valid & ready. x_issue_ready_o = !fifo_full. Both accepted and rejected instructions complete the handshake; only accepted ones are enqueued.
- Each FIFO entry holds {id, op, rs1, rs2, rd, committed, killed}.
- Commit handling: a commit message sets committed (kill=0) or killed (kill=1) on the valid entry with matching id. A commit with no matching entry is ignored.
- Commit arriving in the same cycle as that id's issue handshake: applies to the new entry.
- Execute FSM states:
  - IDLE:
    - head killed → pop, stay IDLE.
    - head committed and NOP → pop, stay IDLE, no result.
    - head committed, ADD/SUB → latch result, pop, go RESP.
    - head committed, MUL → load counter = MulLatency-1, pop, go EXEC.
    - head not committed → wait.
  - EXEC: counter decrements each cycle; at 0, latch product and go RESP.
  - RESP: x_result_valid_o=1. Id/data/rd/we stay stable until x_result_ready_i; on ready go IDLE.
- Latency: ADD/SUB result valid 1 cycle after the cycle in which the head is committed in IDLE; MUL valid MulLatency cycles after that.
- x_result_we_o = 1 for every emitted result.
- Results are emitted in issue order.
- Full FIFO with a simultaneous pop: ready still 0 that cycle (registered-full semantics); no enqueue.
- Pointers wrap modulo FifoDepth; count width is clog2(FifoDepth)+1.
- Reset: FIFO emptied, FSM to IDLE, counter 0. x_issue_ready_o=1 and x_result_valid_o=0 the cycle after reset deasserts. Result id/data/rd/we = 0. Reset mid-operation discards all pending entries and any in-flight result.

Test Plan:
- Issue CUS_ADD (instr 0x0020_80FB-style: funct3=0, rd=1, rs1=0x5, rs2=0x7, id=2), then commit id 2 → accept=1, writeback=1; result id=2, rd=1, data=0xC, one cycle after commit.
- Issue CUS_MUL (rs1=0x10, rs2=0x3, id=4), commit, x_result_ready_i held low 5 cycles → data=0x30 appears 3 cycles after commit; valid and data stable until ready.
- Issue opcode 7'h33 → accept=0, writeback=0, handshake completes, never any result.
- Issue ids 0..3 (ADD), commit with kill on id 1 → results for ids 0, 2, 3 only, in order.
- Issue 4 instructions with no commits → x_issue_ready_o=0 on the 5th; commit id 0 → ready reasserts after pop.
- Assert rst_i during MUL EXEC with 2 entries pending → next cycle ready=1, valid=0; later commits for old ids produce nothing.
